// File: rtl/ripple_count_monitor.sv
// ----------------------------------------------------------------------------
// ripple_count_monitor
//
// Purpose:
//   Consumes the output of a free-running ripple counter. That output is
//   asynchronous to clk and glitches while a carry ripples through it. This
//   block:
//     - brings the value into the clk domain with a two-flop synchroniser;
//     - accepts a value only after it has been stable for STABLE_CYCLES;
//     - computes the modulo-2^CNT_W increment since the last accepted value;
//     - keeps a running total of those increments;
//     - queues {delta, total} records in a small FIFO that is drained through
//       a valid/ready handshake.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   cnt_in     in   raw ripple counter value (asynchronous to clk)
//   enable     in   monitoring enable; a rising enable re-primes the baseline
//   out_ready  in   consumer ready
//   out_valid  out  FIFO head record valid
//   out_delta  out  increment carried by the head record
//   out_total  out  running total after that increment
//   fifo_level out  registered FIFO occupancy
//   overflow   out  sticky: a record was dropped because the FIFO was full
//
// Build option:
//   RCM_SATURATE_EN  when defined, the running total saturates at
//                    2^TOTAL_W-1 instead of wrapping modulo 2^TOTAL_W.
// ----------------------------------------------------------------------------
module ripple_count_monitor #(
    parameter int CNT_W         = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int TOTAL_W       = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CNT_W-1:0]              cnt_in,
    input  logic                          enable,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [CNT_W-1:0]              out_delta,
    output logic [TOTAL_W-1:0]            out_total,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = AW + 1;
    localparam int HOLD_W = $clog2(STABLE_CYCLES + 1);
    localparam int REC_W  = CNT_W + TOTAL_W;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STABLE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        TRACK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Running-total update: wrap or saturate depending on the build.
    // ------------------------------------------------------------------
`ifdef RCM_SATURATE_EN
    function automatic logic [TOTAL_W-1:0] add_total(
        input logic [TOTAL_W-1:0] total,
        input logic [CNT_W-1:0]   delta
    );
        logic [TOTAL_W:0] sum;
        sum = {1'b0, total} + (TOTAL_W+1)'(delta);
        if (sum[TOTAL_W]) begin
            return '1;
        end
        return sum[TOTAL_W-1:0];
    endfunction
`else
    function automatic logic [TOTAL_W-1:0] add_total(
        input logic [TOTAL_W-1:0] total,
        input logic [CNT_W-1:0]   delta
    );
        return total + TOTAL_W'(delta);
    endfunction
`endif

    // Synchroniser and stability filter
    logic [CNT_W-1:0]  s1_q, s2_q;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              sv_ok;
    logic [CNT_W-1:0]  sv;

    // Tracking state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   last_acc_q, last_acc_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [CNT_W-1:0]   delta;
    logic               accept;

    // Record FIFO
    logic [REC_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q;
    logic             full, pop, do_push, drop;
    logic [REC_W-1:0] head;

    // ------------------------------------------------------------------
    // Stage: synchroniser + hold counter.
    // s1/s2 always run. The hold counter restarts at 1 whenever s2 is about
    // to take a new value (s1 != s2), so after the edge it counts how many
    // cycles the current s2 value has been present.
    // ------------------------------------------------------------------
    always_comb begin
        hold_d = hold_q;
        if (s1_q != s2_q) begin
            hold_d = HOLD_ONE;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            hold_q <= '0;
        end else begin
            s1_q   <= cnt_in;
            s2_q   <= s1_q;
            hold_q <= hold_d;
        end
    end

    assign sv_ok = (hold_q == HOLD_MAX);
    assign sv    = s2_q;

    // ------------------------------------------------------------------
    // Stage: accept FSM, delta and running total.
    // Dropping enable always wins; on re-enable the baseline is re-primed
    // so a change that happened while disabled produces no record.
    // ------------------------------------------------------------------
    assign delta = sv - last_acc_q;

    always_comb begin
        state_d    = state_q;
        last_acc_d = last_acc_q;
        total_d    = total_q;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (sv_ok) begin
                    last_acc_d = sv;
                    state_d    = TRACK;
                end
            end
            TRACK: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (sv_ok && (sv != last_acc_q)) begin
                    accept     = 1'b1;
                    last_acc_d = sv;
                    total_d    = add_total(total_q, delta);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_acc_q <= '0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_acc_q <= last_acc_d;
            total_q    <= total_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage: record FIFO.
    // A push into a full FIFO still succeeds if the head is popped in the
    // same cycle; otherwise the record is dropped and overflow latches.
    // ------------------------------------------------------------------
    assign full    = (level_q == LVL_FULL);
    assign pop     = out_valid && out_ready;
    assign do_push = accept && (!full || pop);
    assign drop    = accept && full && !pop;

    always_comb begin
        level_d = level_q;
        case ({do_push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            level_q <= level_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage carries data only; validity comes from the pointers/level.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {delta, total_d};
        end
    end

    // Outputs: head record is forced to zero while the FIFO is empty so the
    // data outputs read 0 after reset and never expose stale storage.
    assign head       = mem_q[rd_ptr_q];
    assign out_valid  = (level_q != '0);
    assign out_delta  = out_valid ? head[REC_W-1:TOTAL_W] : '0;
    assign out_total  = out_valid ? head[TOTAL_W-1:0]     : '0;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
module tb_ripple_count_monitor;

    logic        clk;
    logic        rst;
    logic [3:0]  cnt_in;
    logic        enable;
    logic        out_ready;

    logic        out_valid;
    logic [3:0]  out_delta;
    logic [15:0] out_total;
    logic [2:0]  fifo_level;
    logic        overflow;

    // Narrow-total instance sharing the same stimulus, to exercise wrap/saturate.
    logic        o4_valid;
    logic [3:0]  o4_delta;
    logic [3:0]  o4_total;
    logic [2:0]  o4_level;
    logic        o4_ovf;

    int nvec = 0;
    int nmis = 0;

    ripple_count_monitor #(
        .CNT_W(4), .STABLE_CYCLES(2), .TOTAL_W(16), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .enable(enable),
        .out_ready(out_ready), .out_valid(out_valid), .out_delta(out_delta),
        .out_total(out_total), .fifo_level(fifo_level), .overflow(overflow)
    );

    ripple_count_monitor #(
        .CNT_W(4), .STABLE_CYCLES(2), .TOTAL_W(4), .FIFO_DEPTH(4)
    ) dut4 (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .enable(enable),
        .out_ready(out_ready), .out_valid(o4_valid), .out_delta(o4_delta),
        .out_total(o4_total), .fifo_level(o4_level), .overflow(o4_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp4(input int t);
`ifdef RCM_SATURATE_EN
        return (t > 15) ? 15 : t;
`else
        return t % 16;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One accepted value with out_ready=1: record visible 4 edges after the
    // change, popped on the following edge.
    task automatic step(input logic [3:0] v, input int d, input int t);
        cnt_in = v;
        tick(4);
        chk("step_valid", 32'(out_valid), 1);
        chk("step_delta", 32'(out_delta), 32'(d));
        chk("step_total", 32'(out_total), 32'(t));
        chk("step_total4", 32'(o4_total), 32'(exp4(t)));
        tick(1);
        chk("step_popped", 32'(fifo_level), 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cnt_in = 4'd5; out_ready = 1'b0;
        tick(2);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_delta", 32'(out_delta), 0);
        chk("rst_total", 32'(out_total), 0);
        chk("rst_total4", 32'(o4_total), 0);

        // Prime on 5: no record
        rst = 1'b0; enable = 1'b1;
        tick(6);
        chk("prime_valid", 32'(out_valid), 0);
        chk("prime_level", 32'(fifo_level), 0);
        chk("prime_ovf", 32'(overflow), 0);

        // 5 -> 7, latency check edge by edge
        cnt_in = 4'd7;
        tick(1); chk("lat_e0", 32'(out_valid), 0);
        tick(1); chk("lat_e1", 32'(out_valid), 0);
        tick(1); chk("lat_e2", 32'(out_valid), 0);
        tick(1); chk("lat_e3", 32'(out_valid), 1);
        chk("first_delta", 32'(out_delta), 2);
        chk("first_total", 32'(out_total), 2);
        chk("first_level", 32'(fifo_level), 1);
        chk("first_valid4", 32'(o4_valid), 1);
        out_ready = 1'b1;
        tick(1);
        chk("pop_level", 32'(fifo_level), 0);
        chk("pop_valid", 32'(out_valid), 0);

        // Glitch: 7 -> 6 for one clock -> 8
        cnt_in = 4'd6;
        tick(1);
        cnt_in = 4'd8;
        tick(3);
        chk("glitch_none", 32'(out_valid), 0);
        tick(1);
        chk("glitch_valid", 32'(out_valid), 1);
        chk("glitch_delta", 32'(out_delta), 1);
        chk("glitch_total", 32'(out_total), 3);
        tick(1);
        chk("glitch_level", 32'(fifo_level), 0);

        // 8 -> 14, then wrap 14 -> 1
        step(4'd14, 6, 9);
        step(4'd1, 3, 12);

        // Backpressure: five increments of 1 with out_ready low
        out_ready = 1'b0;
        cnt_in = 4'd2;
        tick(4);
        chk("bp_head_total", 32'(out_total), 13);
        chk("bp_head_delta", 32'(out_delta), 1);
        for (int v = 3; v <= 6; v++) begin
            cnt_in = 4'(v);
            tick(4);
        end
        chk("bp_level", 32'(fifo_level), 4);
        chk("bp_ovf", 32'(overflow), 1);
        chk("bp_head_kept", 32'(out_total), 13);
        chk("bp_head_delta_kept", 32'(out_delta), 1);
        chk("bp_level4", 32'(o4_level), 4);
        chk("bp_ovf4", 32'(o4_ovf), 1);
        chk("bp_delta4", 32'(o4_delta), 1);

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_total", 32'(out_total), 32'(13 + i));
            chk("drain_total4", 32'(o4_total), 32'(exp4(13 + i)));
            tick(1);
        end
        chk("drain_level", 32'(fifo_level), 0);
        step(4'd7, 1, 18);
        chk("ovf_sticky", 32'(overflow), 1);

        // Reset mid-operation discards queued records and clears overflow
        out_ready = 1'b0;
        cnt_in = 4'd8;
        tick(4);
        chk("pre_rst_level", 32'(fifo_level), 1);
        rst = 1'b1;
        tick(2);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        chk("mid_rst_total", 32'(out_total), 0);
        rst = 1'b0;
        tick(8);
        chk("reprime_level", 32'(fifo_level), 0);

        // Fill to 4, then push and pop on the same edge
        for (int v = 9; v <= 12; v++) begin
            cnt_in = 4'(v);
            tick(4);
        end
        chk("full_level", 32'(fifo_level), 4);
        chk("full_head", 32'(out_total), 1);
        cnt_in = 4'd13;
        tick(3);
        chk("pp_before", 32'(fifo_level), 4);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("pp_level", 32'(fifo_level), 4);
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_head", 32'(out_total), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain", 32'(out_total), 32'(2 + i));
            tick(1);
        end
        chk("pp_drain_level", 32'(fifo_level), 0);

        // Enable drop: 13 -> 3 tracked, 3 -> 9 while disabled, re-prime
        step(4'd3, 6, 11);
        enable = 1'b0;
        tick(1);
        cnt_in = 4'd9;
        tick(5);
        chk("dis_valid", 32'(out_valid), 0);
        enable = 1'b1;
        tick(8);
        chk("reen_valid", 32'(out_valid), 0);
        chk("reen_level", 32'(fifo_level), 0);
        step(4'd10, 1, 12);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
